// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate word cache between a CPU request/ready
// port and an asynchronous word memory whose read data settles MEM_LAT cycles after mem_read.
module dm_cache_ctrl #(
    parameter int LINES   = 16,
    parameter int MEM_LAT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_write_data,
    output logic [31:0] cpu_read_data,
    output logic        cpu_ready,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);
    localparam int IDX  = $clog2(LINES);
    localparam int TAGW = 30 - IDX;
    localparam int CNTW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR, DONE} state_t;

    state_t            r_state;
    logic [LINES-1:0]  r_valid;
    logic [TAGW-1:0]   r_tag  [LINES];
    logic [31:0]       r_data [LINES];
    logic [CNTW-1:0]   r_cnt;
    logic [31:0]       r_rdata;
    logic              r_ready;
    logic [31:0]       r_mem_addr;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [31:0]       r_mem_wdata;
    logic [15:0]       r_hits;
    logic [15:0]       r_misses;

    logic [IDX-1:0]    w_req_idx;
    logic [TAGW-1:0]   w_req_tag;
    logic [IDX-1:0]    w_pend_idx;
    logic [TAGW-1:0]   w_pend_tag;
    logic              w_hit;
    logic              w_fill;
    logic [31:0]       w_aligned;
    logic              w_line_we;
    logic [IDX-1:0]    w_line_idx;
    logic [TAGW-1:0]   w_line_tag;
    logic [31:0]       w_line_word;

    assign w_req_idx  = cpu_addr[IDX+1:2];
    assign w_req_tag  = cpu_addr[31:IDX+2];
    assign w_aligned  = cpu_addr & 32'hFFFF_FFFC;
    // The pending miss is tracked through the latched memory address, so a dropped
    // or changed CPU request cannot redirect the fill.
    assign w_pend_idx = r_mem_addr[IDX+1:2];
    assign w_pend_tag = r_mem_addr[31:IDX+2];
    assign w_hit      = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
    assign w_fill     = (r_state == RD_WAIT) && (r_cnt == CNTW'(MEM_LAT));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_line_we   = 1'b0;
        w_line_idx  = w_req_idx;
        w_line_tag  = w_req_tag;
        w_line_word = cpu_write_data;
        if (!reset) begin
            if (r_state == IDLE && cpu_write && w_hit) begin
                w_line_we = 1'b1;
            end else if (w_fill) begin
                w_line_we   = 1'b1;
                w_line_idx  = w_pend_idx;
                w_line_tag  = w_pend_tag;
                w_line_word = mem_read_data;
            end
        end
    end

    // NOTE: tag and data arrays carry no reset; the valid bits alone decide whether they are used.
    always_ff @(posedge clk) begin
        if (w_line_we) begin
            r_tag[w_line_idx]  <= w_line_tag;
            r_data[w_line_idx] <= w_line_word;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_valid     <= '0;
            r_cnt       <= '0;
            r_rdata     <= '0;
            r_ready     <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_wdata <= '0;
            r_hits      <= '0;
            r_misses    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cpu_write) begin
                        r_mem_write <= 1'b1;
                        r_mem_addr  <= w_aligned;
                        r_mem_wdata <= cpu_write_data;
                        r_state     <= WR;
                    end else if (cpu_read) begin
                        if (w_hit) begin
                            r_rdata <= r_data[w_req_idx];
                            r_ready <= 1'b1;
                            if (r_hits != 16'hFFFF) r_hits <= r_hits + 16'd1;
                            r_state <= DONE;
                        end else begin
                            r_mem_read <= 1'b1;
                            r_mem_addr <= w_aligned;
                            r_cnt      <= CNTW'(1);
                            if (r_misses != 16'hFFFF) r_misses <= r_misses + 16'd1;
                            r_state    <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (w_fill) begin
                        r_valid[w_pend_idx] <= 1'b1;
                        r_rdata             <= mem_read_data;
                        r_ready             <= 1'b1;
                        r_mem_read          <= 1'b0;
                        r_state             <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CNTW'(1);
                    end
                end
                WR: begin
                    r_mem_write <= 1'b0;
                    r_ready     <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    // The held request is ignored here so it is not issued a second time.
                    r_ready <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cpu_read_data  = r_rdata;
    assign cpu_ready      = r_ready;
    assign mem_addr       = r_mem_addr;
    assign mem_read       = r_mem_read;
    assign mem_write      = r_mem_write;
    assign mem_write_data = r_mem_wdata;
    assign hit_count      = r_hits;
    assign miss_count     = r_misses;
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl: directed scenarios plus randomized traffic checked
// against a residency/memory model of the cache.
module tb_dm_cache_ctrl;
    localparam int LINES   = 16;
    localparam int MEM_LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cpu_addr = '0;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [31:0] cpu_write_data = '0;
    logic [31:0] cpu_read_data;
    logic        cpu_ready;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Device memory (asynchronous read, rising-edge write) and the model's own view of it.
    logic [31:0] mem       [0:4095];
    logic [31:0] model_mem [0:4095];
    int          resident  [LINES];
    int          m_hits;
    int          m_misses;

    dm_cache_ctrl #(.LINES(LINES), .MEM_LAT(MEM_LAT)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_addr       (cpu_addr),
        .cpu_read       (cpu_read),
        .cpu_write      (cpu_write),
        .cpu_write_data (cpu_write_data),
        .cpu_read_data  (cpu_read_data),
        .cpu_ready      (cpu_ready),
        .mem_addr       (mem_addr),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_addr[13:2]];
    always @(posedge clk) if (mem_write) mem[mem_addr[13:2]] <= mem_write_data;

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) resident[i] = -1;
        m_hits   = 0;
        m_misses = 0;
    endtask

    // A line holds whichever word address last missed into it; write-through keeps the
    // cached word equal to memory, so load data always comes from the model memory.
    task automatic model_step(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] exp_data, output int exp_lat,
                              output int exp_mr, output int exp_mw);
        int word = int'(addr[31:2]);
        int line = word % LINES;
        int mi   = word % 4096;
        exp_data = '0;
        exp_mr   = 0;
        exp_mw   = 0;
        if (wr) begin
            model_mem[mi] = wdata;
            exp_lat = 2;
            exp_mw  = 1;
        end else begin
            exp_data = model_mem[mi];
            if (resident[line] == word) begin
                exp_lat = 1;
                if (m_hits < 65535) m_hits++;
            end else begin
                exp_lat = MEM_LAT + 1;
                exp_mr  = MEM_LAT;
                if (m_misses < 65535) m_misses++;
                resident[line] = word;
            end
        end
    endtask

    // Issues one request and follows it to cpu_ready (bounded); lat = -1 on timeout.
    task automatic cpu_op(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit drop, output logic [31:0] rdata, output int lat,
                          output int mr_cyc, output int mw_cyc, output bit port_ok);
        rdata = '0; lat = -1; mr_cyc = 0; mw_cyc = 0; port_ok = 1'b1;
        @(negedge clk);
        cpu_addr = addr; cpu_write = wr; cpu_read = !wr; cpu_write_data = wdata;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (drop && c == 1) begin
                cpu_read = 1'b0; cpu_write = 1'b0;
                cpu_addr = $urandom; cpu_write_data = $urandom;
            end
            if (mem_read) mr_cyc++;
            if (mem_write) mw_cyc++;
            if ((mem_read || mem_write) && mem_addr !== (addr & 32'hFFFF_FFFC)) port_ok = 1'b0;
            if (mem_write && mem_write_data !== wdata) port_ok = 1'b0;
            if (cpu_ready) begin
                rdata = cpu_read_data;
                lat = c;
                break;
            end
        end
        cpu_read = 1'b0; cpu_write = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (cpu_ready !== 1'b0 || cpu_read_data !== 32'h0) $display("FAIL reset_cpu: ready=%0b data=%h want 0/0", cpu_ready, cpu_read_data); else n_pass++;
        n_checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) $display("FAIL reset_mem_ctl: rd=%0b wr=%0b want 0/0", mem_read, mem_write); else n_pass++;
        n_checks++; if (mem_addr !== 32'h0 || mem_write_data !== 32'h0) $display("FAIL reset_mem_bus: addr=%h wdata=%h want 0/0", mem_addr, mem_write_data); else n_pass++;
        n_checks++; if (hit_count !== 16'h0 || miss_count !== 16'h0) $display("FAIL reset_counters: hit=%0d miss=%0d want 0/0", hit_count, miss_count); else n_pass++;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_plan();
        logic [31:0] d, ed; int lat, mr, mw, el, emr, emw; bit ok;
        // Cold read
        model_step(0, 32'h3000, 0, ed, el, emr, emw);
        cpu_op(0, 32'h3000, 0, 0, d, lat, mr, mw, ok);
        n_checks++; if (d !== 32'h12345678) $display("FAIL cold_data: got %h want 12345678", d); else n_pass++;
        n_checks++; if (lat !== 4) $display("FAIL cold_latency: got %0d want 4", lat); else n_pass++;
        n_checks++; if (mr !== 3 || !ok) $display("FAIL cold_mem_read: cycles=%0d addr_ok=%0b want 3/1", mr, ok); else n_pass++;
        n_checks++; if (miss_count !== 16'd1) $display("FAIL cold_miss_count: got %0d want 1", miss_count); else n_pass++;
        // Hits, including an unaligned byte address in the same word
        for (int i = 0; i < 2; i++) begin
            logic [31:0] a;
            a = (i == 0) ? 32'h3000 : 32'h3002;
            model_step(0, a, 0, ed, el, emr, emw);
            cpu_op(0, a, 0, 0, d, lat, mr, mw, ok);
            n_checks++; if (d !== 32'h12345678 || lat !== 1 || mr !== 0) $display("FAIL hit_%h: data=%h lat=%0d mem_read=%0d want 12345678/1/0", a, d, lat, mr); else n_pass++;
        end
        n_checks++; if (hit_count !== 16'd2) $display("FAIL hit_count: got %0d want 2", hit_count); else n_pass++;
        // Write hit then read back
        model_step(1, 32'h3000, 32'hDEADBEEF, ed, el, emr, emw);
        cpu_op(1, 32'h3000, 32'hDEADBEEF, 0, d, lat, mr, mw, ok);
        n_checks++; if (lat !== 2 || mw !== 1 || !ok) $display("FAIL write_hit: lat=%0d mem_write=%0d port_ok=%0b want 2/1/1", lat, mw, ok); else n_pass++;
        n_checks++; if (mem[12'hC00] !== 32'hDEADBEEF) $display("FAIL write_hit_mem: got %h want deadbeef", mem[12'hC00]); else n_pass++;
        model_step(0, 32'h3000, 0, ed, el, emr, emw);
        cpu_op(0, 32'h3000, 0, 0, d, lat, mr, mw, ok);
        n_checks++; if (d !== 32'hDEADBEEF || lat !== 1) $display("FAIL write_hit_readback: data=%h lat=%0d want deadbeef/1", d, lat); else n_pass++;
        // Conflict at index 0
        model_step(0, 32'h3040, 0, ed, el, emr, emw);
        cpu_op(0, 32'h3040, 0, 0, d, lat, mr, mw, ok);
        n_checks++; if (d !== ed || lat !== 4) $display("FAIL conflict_a: data=%h lat=%0d want %h/4", d, lat, ed); else n_pass++;
        model_step(0, 32'h3000, 0, ed, el, emr, emw);
        cpu_op(0, 32'h3000, 0, 0, d, lat, mr, mw, ok);
        n_checks++; if (d !== 32'hDEADBEEF || lat !== 4 || mr !== 3) $display("FAIL conflict_b: data=%h lat=%0d mem_read=%0d want deadbeef/4/3", d, lat, mr); else n_pass++;
        n_checks++; if (miss_count !== 16'd3) $display("FAIL conflict_miss_count: got %0d want 3", miss_count); else n_pass++;
        // Write miss does not allocate
        model_step(1, 32'h3080, 32'hCAFEF00D, ed, el, emr, emw);
        cpu_op(1, 32'h3080, 32'hCAFEF00D, 0, d, lat, mr, mw, ok);
        n_checks++; if (lat !== 2 || mw !== 1) $display("FAIL write_miss: lat=%0d mem_write=%0d want 2/1", lat, mw); else n_pass++;
        model_step(0, 32'h3080, 0, ed, el, emr, emw);
        cpu_op(0, 32'h3080, 0, 0, d, lat, mr, mw, ok);
        n_checks++; if (d !== 32'hCAFEF00D || lat !== 4) $display("FAIL write_miss_read: data=%h lat=%0d want cafef00d/4", d, lat); else n_pass++;
        n_checks++; if (hit_count !== 16'd3 || miss_count !== 16'd4) $display("FAIL plan_counters: hit=%0d miss=%0d want 3/4", hit_count, miss_count); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, ed; int lat, mr, mw, el, emr, emw, pulses; bit ok;
        @(negedge clk);
        cpu_addr = 32'h3000; cpu_read = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_read !== 1'b1) $display("FAIL rstmid_miss_started: mem_read=%0b want 1", mem_read); else n_pass++;
        @(negedge clk);
        reset = 1'b1; cpu_read = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_read !== 1'b0 || cpu_ready !== 1'b0) $display("FAIL rstmid_outputs: mem_read=%0b ready=%0b want 0/0", mem_read, cpu_ready); else n_pass++;
        n_checks++; if (hit_count !== 16'h0 || miss_count !== 16'h0) $display("FAIL rstmid_counters: hit=%0d miss=%0d want 0/0", hit_count, miss_count); else n_pass++;
        reset = 1'b0;
        model_reset();
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (cpu_ready) pulses++;
        end
        n_checks++; if (pulses !== 0) $display("FAIL rstmid_no_ready: pulses=%0d want 0", pulses); else n_pass++;
        model_step(0, 32'h3000, 0, ed, el, emr, emw);
        cpu_op(0, 32'h3000, 0, 0, d, lat, mr, mw, ok);
        n_checks++; if (lat !== 4 || d !== 32'hDEADBEEF) $display("FAIL rstmid_reread: lat=%0d data=%h want 4/deadbeef", lat, d); else n_pass++;
        n_checks++; if (miss_count !== 16'd1) $display("FAIL rstmid_miss_count: got %0d want 1", miss_count); else n_pass++;
    endtask

    task automatic test_write_reset();
        logic [31:0] ed; int el, emr, emw;
        @(negedge clk);
        cpu_addr = 32'h30C0; cpu_write_data = 32'h0BADC0DE; cpu_write = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_write !== 1'b1) $display("FAIL wrst_mem_write: got %0b want 1", mem_write); else n_pass++;
        reset = 1'b1; cpu_write = 1'b0;
        @(negedge clk);
        n_checks++; if (mem[12'hC30] !== 32'h0BADC0DE) $display("FAIL wrst_mem_word: got %h want 0badc0de", mem[12'hC30]); else n_pass++;
        n_checks++; if (mem_write !== 1'b0 || cpu_ready !== 1'b0) $display("FAIL wrst_outputs: mem_write=%0b ready=%0b want 0/0", mem_write, cpu_ready); else n_pass++;
        reset = 1'b0;
        model_step(1, 32'h30C0, 32'h0BADC0DE, ed, el, emr, emw);
        model_reset();
    endtask

    task automatic test_random();
        logic [31:0] d, ed, a, wd; int lat, mr, mw, el, emr, emw; bit ok, wr, drop;
        for (int n = 0; n < 250; n++) begin
            wr   = ($urandom_range(0, 9) < 3);
            a    = 32'h3000 + (32'($urandom_range(0, 63)) << 2) + 32'($urandom_range(0, 3));
            wd   = $urandom;
            drop = ($urandom_range(0, 7) == 0);
            model_step(wr, a, wd, ed, el, emr, emw);
            cpu_op(wr, a, wd, drop, d, lat, mr, mw, ok);
            n_checks++; if (lat !== el || mr !== emr || mw !== emw) $display("FAIL rand_timing #%0d addr=%h wr=%0b: lat=%0d mr=%0d mw=%0d want %0d/%0d/%0d", n, a, wr, lat, mr, mw, el, emr, emw); else n_pass++;
            n_checks++; if (!ok) $display("FAIL rand_mem_port #%0d addr=%h: memory address/data wrong", n, a); else n_pass++;
            if (!wr) begin
                n_checks++; if (d !== ed) $display("FAIL rand_data #%0d addr=%h: got %h want %h", n, a, d, ed); else n_pass++;
            end
        end
        n_checks++; if (hit_count !== 16'(m_hits) || miss_count !== 16'(m_misses)) $display("FAIL rand_counters: hit=%0d miss=%0d want %0d/%0d", hit_count, miss_count, m_hits, m_misses); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, ed; int lat, mr, mw, el, emr, emw, pulses, consec; bit ok, prev;
        model_step(0, 32'h3004, 0, ed, el, emr, emw);
        cpu_op(0, 32'h3004, 0, 0, d, lat, mr, mw, ok);
        n_checks++; if (lat !== el || d !== ed) $display("FAIL b2b_prime: lat=%0d data=%h want %0d/%h", lat, d, el, ed); else n_pass++;
        pulses = 0; consec = 0; prev = 1'b0;
        @(negedge clk);
        cpu_addr = 32'h3004; cpu_read = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (cpu_ready) begin
                pulses++;
                if (prev) consec++;
                n_checks++; if (cpu_read_data !== ed) $display("FAIL b2b_data: got %h want %h", cpu_read_data, ed); else n_pass++;
            end
            prev = cpu_ready;
        end
        cpu_read = 1'b0;
        for (int i = 0; i < 20; i++) model_step(0, 32'h3004, 0, ed, el, emr, emw);
        n_checks++; if (pulses !== 20 || consec !== 0) $display("FAIL b2b_pulses: got %0d (adjacent %0d) want 20 (0)", pulses, consec); else n_pass++;
        n_checks++; if (hit_count !== 16'(m_hits)) $display("FAIL b2b_hit_count: got %0d want %0d", hit_count, m_hits); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            logic [31:0] v;
            v = $urandom;
            mem[i] = v;
            model_mem[i] = v;
        end
        mem[12'hC00] = 32'h12345678;
        model_mem[12'hC00] = 32'h12345678;
        test_reset();
        test_plan();
        test_reset_mid();
        test_write_reset();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
